// File: rtl/jdec_pkg.sv
`default_nettype none
// ============================================================================
// Module      : jdec_pkg
// Description : Shared types and helpers for the Johnson-code decoder/lock
//               block: lock FSM state encoding and decoded-count width.
// Revision    : 1.0 - initial release
// ============================================================================
package jdec_pkg;

    // Lock FSM states
    typedef enum logic [0:0] {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } state_t;

    // Width of the decoded sequence index for an n-stage Johnson counter
    function automatic int jdec_cw(input int n);
        return $clog2(2 * n);
    endfunction

endpackage : jdec_pkg
`default_nettype wire

// File: rtl/johnson_to_bin.sv
`default_nettype none
// ============================================================================
// Module      : johnson_to_bin
// Description : Combinational Johnson-code to binary-index converter with a
//               legality flag (at most one adjacent-bit transition).
// Revision    : 1.0 - initial release
// ============================================================================
module johnson_to_bin #(
    parameter int N  = 4,
    parameter int CW = 3
) (
    input  wire logic [N-1:0]  i_jc,
    output logic      [CW-1:0] o_idx,
    output logic               o_legal
);

    localparam logic [CW:0] c_TWO_N = (CW+1)'(2 * N);

    logic [CW:0] w_pop;
    logic [4:0]  w_trans;

    // Count ones and adjacent transitions, then map the popcount to an index
    always_comb begin
        w_pop   = '0;
        w_trans = '0;
        for (int i = 0; i < N; i++) begin
            w_pop = w_pop + (CW+1)'(i_jc[i]);
        end
        for (int i = 0; i < N - 1; i++) begin
            w_trans = w_trans + 5'(i_jc[i] ^ i_jc[i+1]);
        end
        o_legal = (w_trans <= 5'd1);
        // First half of the cycle fills ones from the MSB; second half drains them
        if (i_jc[N-1] || (w_pop == '0)) begin
            o_idx = w_pop[CW-1:0];
        end else begin
            o_idx = CW'(c_TWO_N - w_pop);
        end
    end

endmodule : johnson_to_bin
`default_nettype wire

// File: rtl/johnson_decoder_lock.sv
`default_nettype none
// ============================================================================
// Module      : johnson_decoder_lock
// Description : Decodes sampled Johnson code words to a binary index, flags
//               illegal words and tracks lock on a run of +1 steps.
//               Optional feature macro: JDEC_ERR_CNT_EN (loss-of-lock counter).
// Revision    : 1.0 - initial release
// ============================================================================
module johnson_decoder_lock
    import jdec_pkg::*;
#(
    parameter  int N        = 4,
    parameter  int LOCK_CNT = 3,
    parameter  int ERR_W    = 8,
    localparam int CW       = jdec_cw(N)
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic [N-1:0]     i_jc_in,
    input  wire logic             i_jc_valid,
    input  wire logic             i_err_clr,
    output logic      [CW-1:0]    o_count,
    output logic                  o_count_valid,
    output logic                  o_illegal,
    output logic                  o_step_err,
    output logic                  o_locked,
    output logic      [ERR_W-1:0] o_err_cnt
);

    localparam logic [CW-1:0] c_LAST_IDX = CW'(2 * N - 1);
    localparam logic [3:0]    c_LOCK_CNT = 4'(LOCK_CNT);

    logic [CW-1:0] w_idx;
    logic          w_legal;

    state_t        r_state,    w_state_nxt;
    logic [CW-1:0] r_prev_idx, w_prev_idx_nxt;
    logic          r_prev_ok,  w_prev_ok_nxt;
    logic [3:0]    r_run,      w_run_nxt;
    logic [CW-1:0] r_count,    w_count_nxt;
    logic          r_count_valid, w_count_valid_nxt;
    logic          r_illegal,     w_illegal_nxt;
    logic          r_step_err,    w_step_err_nxt;
    logic          w_err_evt;

    logic [CW-1:0] w_succ;
    logic          w_is_step;
    logic [3:0]    w_run_inc;

    johnson_to_bin #(
        .N  (N),
        .CW (CW)
    ) u_j2b (
        .i_jc    (i_jc_in),
        .o_idx   (w_idx),
        .o_legal (w_legal)
    );

    // Successor of the previous index, wrapping 2N-1 back to 0
    assign w_succ    = (r_prev_idx == c_LAST_IDX) ? '0 : r_prev_idx + 1'b1;
    assign w_is_step = r_prev_ok && (w_idx == w_succ);
    assign w_run_inc = r_run + 4'd1;

    // Next-state, tracking registers and output pulses
    always_comb begin
        w_state_nxt       = r_state;
        w_prev_idx_nxt    = r_prev_idx;
        w_prev_ok_nxt     = r_prev_ok;
        w_run_nxt         = r_run;
        w_count_nxt       = r_count;
        w_count_valid_nxt = 1'b0;
        w_illegal_nxt     = 1'b0;
        w_step_err_nxt    = 1'b0;
        w_err_evt         = 1'b0;
        if (i_jc_valid) begin
            if (!w_legal) begin
                // Illegal word takes precedence over any step error
                w_illegal_nxt = 1'b1;
                w_prev_ok_nxt = 1'b0;
                w_run_nxt     = '0;
                w_state_nxt   = UNLOCKED;
                w_err_evt     = (r_state == LOCKED);
            end else begin
                w_count_nxt       = w_idx;
                w_count_valid_nxt = 1'b1;
                w_prev_idx_nxt    = w_idx;
                w_prev_ok_nxt     = 1'b1;
                case (r_state)
                    UNLOCKED: begin
                        if (w_is_step) begin
                            w_run_nxt = w_run_inc;
                            if (w_run_inc == c_LOCK_CNT) begin
                                w_state_nxt = LOCKED;
                            end
                        end else begin
                            w_run_nxt = '0;
                        end
                    end
                    LOCKED: begin
                        if (!w_is_step) begin
                            w_step_err_nxt = 1'b1;
                            w_state_nxt    = UNLOCKED;
                            w_run_nxt      = '0;
                            w_err_evt      = 1'b1;
                        end
                    end
                    default: w_state_nxt = UNLOCKED;
                endcase
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= UNLOCKED;
            r_prev_idx    <= '0;
            r_prev_ok     <= 1'b0;
            r_run         <= '0;
            r_count       <= '0;
            r_count_valid <= 1'b0;
            r_illegal     <= 1'b0;
            r_step_err    <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_prev_idx    <= w_prev_idx_nxt;
            r_prev_ok     <= w_prev_ok_nxt;
            r_run         <= w_run_nxt;
            r_count       <= w_count_nxt;
            r_count_valid <= w_count_valid_nxt;
            r_illegal     <= w_illegal_nxt;
            r_step_err    <= w_step_err_nxt;
        end
    end

`ifdef JDEC_ERR_CNT_EN
    logic [ERR_W-1:0] r_err_cnt;

    // Saturating loss-of-lock counter; clear beats a coincident increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= '0;
        end else if (i_err_clr) begin
            r_err_cnt <= '0;
        end else if (w_err_evt && (r_err_cnt != '1)) begin
            r_err_cnt <= r_err_cnt + 1'b1;
        end
    end

    assign o_err_cnt = r_err_cnt;
`else
    logic w_unused_err;
    assign w_unused_err = i_err_clr | w_err_evt;
    assign o_err_cnt    = '0;
`endif

    assign o_count       = r_count;
    assign o_count_valid = r_count_valid;
    assign o_illegal     = r_illegal;
    assign o_step_err    = r_step_err;
    assign o_locked      = (r_state == LOCKED);

endmodule : johnson_decoder_lock
`default_nettype wire
